// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions for the MEM stage: writeback-select
//               encodings, MEM-stage FSM state type, the MEM/WB field bundle
//               and its bubble value.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // Writeback select encodings (2'b11 is reserved and behaves as ALU at WB)
   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC4 = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Everything the WB stage consumes from the MEM/WB register
   typedef struct packed {
      logic        RegWrite;
      logic [1:0]  WDSel;
      logic [31:0] ALU_result;
      logic [31:0] mem_rdata;
      logic [4:0]  wregnum;
      logic [31:0] PCPLUS4;
   } memwb_t;

   // A bubble never writes the register file
   localparam memwb_t c_MEMWB_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Signal bundle between the MEM-stage controller and its
//               surroundings (EXE/MEM register, data memory, WB stage,
//               hazard/stall fan-out).
// Ports       : none; modports
//               master - the MEM-stage controller
//               slave  - the environment (pipeline, memory, WB)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;

   // EXE/MEM inputs and flush
   logic        clr;
   logic        RegWrite_in;
   logic        mem_w_in;
   logic [3:0]  wea_in;
   logic [1:0]  WDSel_in;
   logic [31:0] ALU_result_in;
   logic [31:0] ALU_B_in;
   logic [4:0]  wregnum_in;
   logic [31:0] PCPLUS4_in;

   // Data memory handshake
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_wea;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;

   // Pipeline control and WB outputs
   logic        stall;
   logic        RegWrite_out;
   logic [1:0]  WDSel_out;
   logic [31:0] ALU_result_out;
   logic [31:0] mem_rdata_out;
   logic [4:0]  wregnum_out;
   logic [31:0] PCPLUS4_out;
   logic        bus_err;

   modport master (
      input  clr, RegWrite_in, mem_w_in, wea_in, WDSel_in, ALU_result_in,
             ALU_B_in, wregnum_in, PCPLUS4_in, dm_rdata, dm_ack,
      output dm_req, dm_we, dm_wea, dm_addr, dm_wdata, stall, RegWrite_out,
             WDSel_out, ALU_result_out, mem_rdata_out, wregnum_out,
             PCPLUS4_out, bus_err
   );

   modport slave (
      output clr, RegWrite_in, mem_w_in, wea_in, WDSel_in, ALU_result_in,
             ALU_B_in, wregnum_in, PCPLUS4_in, dm_rdata, dm_ack,
      input  dm_req, dm_we, dm_wea, dm_addr, dm_wdata, stall, RegWrite_out,
             WDSel_out, ALU_result_out, mem_rdata_out, wregnum_out,
             PCPLUS4_out, bus_err
   );

endinterface
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_reg
// Description : MEM/WB pipeline register. Flush (i_clr) loads a bubble and
//               takes priority over the write enable.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset
//               i_we  - load i_d
//               i_clr - load bubble
//               i_d   - next MEM/WB field set
//               o_q   - registered MEM/WB field set
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg
   import cpu_pkg::*;
(
   input  wire logic   clk,
   input  wire logic   rst_n,
   input  wire logic   i_we,
   input  wire logic   i_clr,
   input  wire memwb_t i_d,
   output memwb_t      o_q
);

   memwb_t r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= c_MEMWB_BUBBLE;
      end else if (i_clr) begin
         r_q <= c_MEMWB_BUBBLE;
      end else if (i_we) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage controller. Issues a registered req/ack access to a
//               multi-cycle data memory for loads and stores, stalls the
//               upstream stages while the access is outstanding, force-
//               completes it after TIMEOUT_CYCLES (sticky bus_err) and feeds
//               the MEM/WB register.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset
//               bus   - mem_access_ctrl_if.master (EXE/MEM inputs, clr,
//                       data memory handshake, stall, MEM/WB outputs, bus_err)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
   import cpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
)(
   input  wire logic          clk,
   input  wire logic          rst_n,
   mem_access_ctrl_if.master  bus
);

   // Timeout fires on the WAIT cycle in which the counter would reach
   // TIMEOUT_CYCLES, so an unacknowledged access spends exactly
   // TIMEOUT_CYCLES cycles in WAIT.
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_buf;
   logic               r_squash;
   logic               r_bus_err;
   logic               r_dm_req;
   logic               r_dm_we;
   logic [3:0]         r_dm_wea;
   logic [31:0]        r_dm_addr;
   logic [31:0]        r_dm_wdata;

   logic               w_access;
   logic               w_stall;
   logic               w_wb_we;
   logic               w_wb_clr;
   logic [31:0]        w_rdata_sel;
   memwb_t             w_wb_d;
   memwb_t             w_wb_q;

   assign w_access = bus.mem_w_in | (bus.WDSel_in == WD_MEM);

   // Stall and MEM/WB control are decoded from state so that upstream sees
   // the stall in the same cycle the access is first presented.
   always_comb begin
      w_stall     = 1'b0;
      w_wb_we     = 1'b0;
      w_wb_clr    = 1'b0;
      w_rdata_sel = 32'h0;
      case (r_state)
         IDLE: begin
            if (bus.clr) begin
               w_wb_clr = 1'b1;          // flush beats a pending access
            end else if (w_access) begin
               w_stall  = 1'b1;          // MEM/WB holds while the access runs
            end else begin
               w_wb_we  = 1'b1;
            end
         end
         WAIT: begin
            w_stall = 1'b1;
         end
         DONE: begin
            w_rdata_sel = r_buf;
            if (r_squash || bus.clr) begin
               w_wb_clr = 1'b1;
            end else begin
               w_wb_we  = 1'b1;
            end
         end
         default: begin
            w_stall = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_wb_d            = c_MEMWB_BUBBLE;
      w_wb_d.RegWrite   = bus.RegWrite_in;
      w_wb_d.WDSel      = bus.WDSel_in;
      w_wb_d.ALU_result = bus.ALU_result_in;
      w_wb_d.mem_rdata  = w_rdata_sel;
      w_wb_d.wregnum    = bus.wregnum_in;
      w_wb_d.PCPLUS4    = bus.PCPLUS4_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_buf      <= 32'h0;
         r_squash   <= 1'b0;
         r_bus_err  <= 1'b0;
         r_dm_req   <= 1'b0;
         r_dm_we    <= 1'b0;
         r_dm_wea   <= 4'h0;
         r_dm_addr  <= 32'h0;
         r_dm_wdata <= 32'h0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (!bus.clr && w_access) begin
                  r_dm_req   <= 1'b1;
                  r_dm_we    <= bus.mem_w_in;
                  r_dm_wea   <= bus.mem_w_in ? bus.wea_in : 4'h0;
                  r_dm_addr  <= {bus.ALU_result_in[31:2], 2'b00};
                  r_dm_wdata <= bus.ALU_B_in;
                  r_squash   <= 1'b0;
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               // A flush cannot abandon the bus cycle; remember it for DONE.
               if (bus.clr) begin
                  r_squash <= 1'b1;
               end
               // Ack is checked first so a same-cycle ack beats the timeout.
               if (bus.dm_ack) begin
                  r_buf    <= bus.dm_rdata;
                  r_dm_req <= 1'b0;
                  r_dm_we  <= 1'b0;
                  r_state  <= DONE;
               end else if (r_cnt == c_CNT_LAST) begin
                  r_buf     <= 32'h0;
                  r_bus_err <= 1'b1;
                  r_dm_req  <= 1'b0;
                  r_dm_we   <= 1'b0;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               r_cnt    <= '0;
               r_squash <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   mem_wb_reg u_mem_wb_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_wb_we),
      .i_clr (w_wb_clr),
      .i_d   (w_wb_d),
      .o_q   (w_wb_q)
   );

   assign bus.stall          = w_stall;
   assign bus.dm_req         = r_dm_req;
   assign bus.dm_we          = r_dm_we;
   assign bus.dm_wea         = r_dm_wea;
   assign bus.dm_addr        = r_dm_addr;
   assign bus.dm_wdata       = r_dm_wdata;
   assign bus.bus_err        = r_bus_err;
   assign bus.RegWrite_out   = w_wb_q.RegWrite;
   assign bus.WDSel_out      = w_wb_q.WDSel;
   assign bus.ALU_result_out = w_wb_q.ALU_result;
   assign bus.mem_rdata_out  = w_wb_q.mem_rdata;
   assign bus.wregnum_out    = w_wb_q.wregnum;
   assign bus.PCPLUS4_out    = w_wb_q.PCPLUS4;

endmodule
`default_nettype wire
